// File: rtl/asic_ioring_pkg.sv
// rtl/asic_ioring_pkg.sv - shared state encoding and constants for the IO ring sequencer
package asic_ioring_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_RAMPUP = 3'd2;
    localparam logic [2:0] ST_ON     = 3'd3;
    localparam logic [2:0] ST_RAMPDN = 3'd4;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_RAMPUP = ST_RAMPUP,
        S_ON     = ST_ON,
        S_RAMPDN = ST_RAMPDN
    } state_e;

endpackage

// File: rtl/asic_ioring_seq_if.sv
// rtl/asic_ioring_seq_if.sv - control/status bundle between core and ring sequencer
// master drives en/vddio_ok/dly/step; slave (the sequencer) drives ctrlring/ready/busy/fault.
interface asic_ioring_seq_if #(
    parameter int NCTRL = 8,
    parameter int CW    = 16
);
    logic             en;
    logic             vddio_ok;
    logic [CW-1:0]    dly;
    logic [CW-1:0]    step;
    logic [NCTRL-1:0] ctrlring;
    logic             ready;
    logic             busy;
    logic             fault;

    modport master (
        output en, vddio_ok, dly, step,
        input  ctrlring, ready, busy, fault
    );

    modport slave (
        input  en, vddio_ok, dly, step,
        output ctrlring, ready, busy, fault
    );
endinterface

// File: rtl/asic_dsync.sv
// rtl/asic_dsync.sv - multi-flop synchronizer for a single asynchronous level
// Ports: clk, nreset (async active-low), i_d (async level), o_q (synchronized level).
module asic_dsync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic nreset,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/asic_ioring_seq.sv
// rtl/asic_ioring_seq.sv - padring control-ring power sequencer
// Ports: clk, nreset (async active-low); bus (slave): en, vddio_ok, dly, step in;
//        ctrlring, ready, busy, fault out (all registered).
module asic_ioring_seq
    import asic_ioring_pkg::*;
#(
    parameter int NCTRL = 8,
    parameter int CW    = 16
) (
    input  logic               clk,
    input  logic               nreset,
    asic_ioring_seq_if.slave   bus
);
    localparam int             IW      = (NCTRL > 1) ? $clog2(NCTRL) : 1;
    localparam logic [IW-1:0]  IDX_TOP = IW'(NCTRL - 1);

    state_e           r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [CW-1:0]    r_dly_q, w_dly_nxt;
    logic [CW-1:0]    r_step_q, w_step_nxt;
    logic [IW-1:0]    r_idx, w_idx_nxt;
    logic [NCTRL-1:0] r_ctrl, w_ctrl_nxt;
    logic             r_ready, w_ready_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_fault, w_fault_nxt;
    logic             w_pwr_s;
    logic             w_step_hit;

    asic_dsync #(.STAGES(SYNC_STAGES)) u_pwr_sync (
        .clk    (clk),
        .nreset (nreset),
        .i_d    (bus.vddio_ok),
        .o_q    (w_pwr_s)
    );

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_dly_q  <= '0;
            r_step_q <= '0;
            r_idx    <= '0;
            r_ctrl   <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dly_q  <= w_dly_nxt;
            r_step_q <= w_step_nxt;
            r_idx    <= w_idx_nxt;
            r_ctrl   <= w_ctrl_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_fault  <= w_fault_nxt;
        end
    end

    assign w_step_hit = (r_cnt == r_step_q);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dly_nxt   = r_dly_q;
        w_step_nxt  = r_step_q;
        w_idx_nxt   = r_idx;
        w_ctrl_nxt  = r_ctrl;
        w_fault_nxt = r_fault;

        case (r_state)
            S_IDLE: begin
                if (r_fault) begin
                    // Sticky fault only drops once the requester withdraws en.
                    if (!bus.en) w_fault_nxt = 1'b0;
                end else if (bus.en && w_pwr_s) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = '0;
                    w_dly_nxt   = bus.dly;
                    w_step_nxt  = bus.step;
                end
            end
            S_SETTLE: begin
                if (!bus.en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == r_dly_q) begin
                    w_state_nxt = S_RAMPUP;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RAMPUP: begin
                // r_idx counts the bits already set, so r_idx-1 is the highest set bit.
                if (!bus.en) begin
                    w_cnt_nxt = '0;
                    if (r_idx == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_RAMPDN;
                        w_idx_nxt   = r_idx - 1'b1;
                    end
                end else if (w_step_hit) begin
                    w_ctrl_nxt[r_idx] = 1'b1;
                    w_cnt_nxt         = '0;
                    if (r_idx == IDX_TOP) w_state_nxt = S_ON;
                    else                  w_idx_nxt   = r_idx + 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ON: begin
                if (!bus.en) begin
                    w_state_nxt = S_RAMPDN;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = IDX_TOP;
                end
            end
            S_RAMPDN: begin
                // en is deliberately ignored here: a ramp-down always runs to completion.
                if (w_step_hit) begin
                    w_ctrl_nxt[r_idx] = 1'b0;
                    w_cnt_nxt         = '0;
                    if (r_idx == '0) w_state_nxt = S_IDLE;
                    else             w_idx_nxt   = r_idx - 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ctrl_nxt  = '0;
            end
        endcase

        // Supply loss overrides everything outside IDLE: drop the ring at once.
        if ((r_state != S_IDLE) && !w_pwr_s) begin
            w_state_nxt = S_IDLE;
            w_ctrl_nxt  = '0;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_fault_nxt = 1'b1;
        end

        w_ready_nxt = (w_state_nxt == S_ON);
        w_busy_nxt  = (w_state_nxt == S_SETTLE) || (w_state_nxt == S_RAMPUP) ||
                      (w_state_nxt == S_RAMPDN);
    end

    assign bus.ctrlring = r_ctrl;
    assign bus.ready    = r_ready;
    assign bus.busy     = r_busy;
    assign bus.fault    = r_fault;
endmodule

// File: tb/tb_asic_ioring_seq.sv
// tb/tb_asic_ioring_seq.sv - self-checking bench for asic_ioring_seq
module tb_asic_ioring_seq;
    localparam int NCTRL = 4;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic nreset;
    always #5 clk = ~clk;

    asic_ioring_seq_if #(.NCTRL(NCTRL), .CW(CW)) bus ();

    asic_ioring_seq #(.NCTRL(NCTRL), .CW(CW)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dly;
        int step;
        int a;          // edge (after en-sampling edge 0) that samples en low
        int exp_n;      // bits that get set before the abort / power-down
        int exp_done;   // edge at which busy returns to 0 in IDLE
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int t, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    function automatic int t_bit(input int dly, input int step, input int k);
        return dly + 1 + (k + 1) * (step + 1);
    endfunction

    function automatic int bits_before(input int dly, input int step, input int a);
        int n = 0;
        for (int k = 0; k < NCTRL; k++)
            if (t_bit(dly, step, k) < a) n++;
        return n;
    endfunction

    // Expected {ctrlring, ready, busy, fault} at edge t, derived from the timing rules.
    function automatic logic [31:0] model(input int dly, input int step, input int a, input int t);
        logic [NCTRL-1:0] ctrl = '0;
        logic rdy = 1'b0;
        logic bsy = 1'b0;
        int n = bits_before(dly, step, a);
        int c;
        if (t < a) begin
            for (int k = 0; k < NCTRL; k++)
                if (t_bit(dly, step, k) <= t) ctrl[k] = 1'b1;
            rdy = (t >= t_bit(dly, step, NCTRL - 1));
            bsy = !rdy;
        end else begin
            c = (t - a) / (step + 1);
            if (c > n) c = n;
            for (int k = 0; k < n - c; k++) ctrl[k] = 1'b1;
            bsy = (c < n);
        end
        return 32'({ctrl, rdy, bsy, 1'b0});
    endfunction

    function automatic logic [31:0] observed();
        return 32'({bus.ctrlring, bus.ready, bus.busy, bus.fault});
    endfunction

    task automatic run_scenario(input int dly, input int step, input int a,
                                output int obs_n, output int obs_done);
        int n    = bits_before(dly, step, a);
        int done = (n == 0) ? a : a + n * (step + 1);
        obs_n    = 0;
        obs_done = -1;
        @(posedge clk); #1;
        bus.dly  = CW'(dly);
        bus.step = CW'(step);
        bus.en   = 1'b1;
        for (int t = 0; t <= done + 2; t++) begin
            @(posedge clk); #1;
            // Shadowed values were captured at edge 0; scribbling here must not matter.
            if (t == 0) begin
                bus.dly  = CW'($urandom);
                bus.step = CW'($urandom);
            end
            chk("cycle", t, observed(), model(dly, step, a, t));
            if ($countones(bus.ctrlring) > obs_n) obs_n = $countones(bus.ctrlring);
            if (t >= a && obs_done < 0 && !bus.busy) obs_done = t;
            if (t == a - 1) bus.en = 1'b0;
        end
        bus.en = 1'b0;
    endtask

    initial begin
        int on, od, dly, step, a;

        vecs.push_back('{3, 2,  19, 4, 31});   // full power-up then power-down
        vecs.push_back('{0, 0,   8, 4, 12});   // dly=0/step=0: bits on edges 2..5
        vecs.push_back('{3, 2,  12, 2, 18});   // abort after bits 0-1
        vecs.push_back('{5, 1,   3, 0,  3});   // abort in SETTLE
        vecs.push_back('{1, 1,   4, 0,  4});   // en falls on the edge bit 0 would set
        vecs.push_back('{1, 1,   5, 1,  7});   // en falls right after bit 0
        vecs.push_back('{0, 255, 258, 1, 514}); // step all-ones: 256 cycles per bit

        // Reset with en/vddio_ok already high.
        nreset       = 1'b0;
        bus.en       = 1'b1;
        bus.vddio_ok = 1'b1;
        bus.dly      = CW'(20);
        bus.step     = CW'(1);
        repeat (3) @(posedge clk);
        #1 chk("reset", 0, observed(), 32'h0);
        nreset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 chk("rst_edge2_busy", 2, 32'(bus.busy), 32'h0);
        @(posedge clk); #1 chk("rst_edge3_busy", 3, 32'(bus.busy), 32'h1);
        bus.en = 1'b0;
        @(posedge clk); #1 chk("settle_abort", 4, observed(), 32'h0);

        foreach (vecs[i]) begin
            run_scenario(vecs[i].dly, vecs[i].step, vecs[i].a, on, od);
            chk("vec_nbits", i, 32'(on), 32'(vecs[i].exp_n));
            chk("vec_done", i, 32'(od), 32'(vecs[i].exp_done));
        end

        for (int r = 0; r < 30; r++) begin
            dly  = $urandom_range(0, 6);
            step = $urandom_range(0, 4);
            a    = $urandom_range(1, t_bit(dly, step, NCTRL - 1) + 4);
            run_scenario(dly, step, a, on, od);
            chk("rand_nbits", r, 32'(on), 32'(bits_before(dly, step, a)));
        end

        // Supply loss while ON.
        bus.dly  = '0;
        bus.step = '0;
        @(posedge clk); #1 bus.en = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("loss_on", 0, observed(), 32'h7c);   // ctrl=f, ready=1
        bus.vddio_ok = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 chk("loss_edge2", 2, observed(), 32'h7c);
        @(posedge clk); #1 chk("loss_edge3", 3, observed(), 32'h01);
        bus.vddio_ok = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("fault_hold", 0, observed(), 32'h01);
        bus.en = 1'b0;
        @(posedge clk); #1 chk("fault_clear", 0, observed(), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
